// File: rtl/athena_side_pkg.sv
// Shared types and phase constants for the side-layer VRAM arbiter.
package athena_side_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, ACK} arb_state_t;

    typedef logic [2:0] phase_t;

    localparam phase_t PH_VLK = 3'd7;
    localparam phase_t PH_H2  = 3'd1;
    localparam phase_t PH_H1  = 3'd3;
    localparam phase_t PH_H0  = 3'd5;

endpackage

// File: rtl/athena_side_phase_gen.sv
// Pixel phase counter, tile-pipeline strobes and the video-window mux select.
module athena_side_phase_gen
    import athena_side_pkg::*;
#(
    parameter int VID_SLOT_START = 6
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   ck1,
    output phase_t phase,
    output logic   v_c,
    output logic   vlk,
    output logic   h2n,
    output logic   h1n,
    output logic   h0n
);

    localparam phase_t SLOT_START = phase_t'(VID_SLOT_START);

    // Strobes decode the phase before it advances on the same CK1 edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            vlk   <= 1'b0;
            h2n   <= 1'b0;
            h1n   <= 1'b0;
            h0n   <= 1'b0;
        end else begin
            vlk <= ck1 && (phase == PH_VLK);
            h2n <= ck1 && (phase == PH_H2);
            h1n <= ck1 && (phase == PH_H1);
            h0n <= ck1 && (phase == PH_H0);
            if (ck1) begin
                phase <= phase + 3'd1;
            end
        end
    end

    assign v_c = (phase < SLOT_START);

endmodule

// File: rtl/athena_side_vram_arbiter.sv
// Side-layer 2Kx8 VRAM sequencer: shares the SRAM between the Z80 port and video fetch.
// Optional stall counter output when ATHENA_SIDE_ARB_STATS_EN is defined.
module athena_side_vram_arbiter
    import athena_side_pkg::*;
#(
    parameter int ACC_CYC        = 2,
    parameter int VID_SLOT_START = 6
) (
    input  logic        clk,
    input  logic        VIDEO_RST,
    input  logic        CK1,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [10:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,
    output logic        cpu_busy,
    output logic [10:0] VA,
    output logic [7:0]  VD_wr,
    input  logic [7:0]  VD_rd,
    output logic        V_C,
    output logic        SIDE_VRAM_CSn,
    output logic        VOE,
    output logic        VWE,
    output logic        VDG,
    output logic        VRD,
    output logic        VLK,
    output logic        H2n,
    output logic        H1n,
    output logic        H0n,
    output logic [2:0]  phase
`ifdef ATHENA_SIDE_ARB_STATS_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam logic [1:0] ACC_LOAD = 2'(ACC_CYC - 1);
    localparam int         WAIT_MAX = VID_SLOT_START - 3;

    arb_state_t state, state_nxt;
    logic [1:0] acc_cnt;
    logic       we_q;
    logic       acc_last;
    logic       slot_ok;

    athena_side_phase_gen #(
        .VID_SLOT_START(VID_SLOT_START)
    ) u_phase_gen (
        .clk  (clk),
        .rst  (VIDEO_RST),
        .ck1  (CK1),
        .phase(phase),
        .v_c  (V_C),
        .vlk  (VLK),
        .h2n  (H2n),
        .h1n  (H1n),
        .h0n  (H0n)
    );

    assign acc_last = (acc_cnt == 2'd0);
    // Starting no later than WAIT_MAX leaves two full pixels before the video slot.
    assign slot_ok  = CK1 && (int'(phase) <= WAIT_MAX);

    always_ff @(posedge clk) begin
        if (VIDEO_RST) begin
            state    <= IDLE;
            acc_cnt  <= '0;
            we_q     <= 1'b0;
            VA       <= '0;
            VD_wr    <= '0;
            cpu_dout <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && cpu_req) begin
                we_q  <= cpu_we;
                VA    <= cpu_addr;
                VD_wr <= cpu_din;
            end
            if (state == WAIT) begin
                acc_cnt <= ACC_LOAD;
            end else if (state == ACCESS && !acc_last) begin
                acc_cnt <= acc_cnt - 2'd1;
            end
            if (state == ACCESS && acc_last && !we_q) begin
                cpu_dout <= VD_rd;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        SIDE_VRAM_CSn = 1'b1;
        VOE           = 1'b1;
        VWE           = 1'b1;
        VDG           = 1'b1;
        VRD           = 1'b0;
        cpu_ack       = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) state_nxt = WAIT;
            end
            WAIT: begin
                if (slot_ok) state_nxt = ACCESS;
            end
            ACCESS: begin
                SIDE_VRAM_CSn = 1'b0;
                VDG           = 1'b0;
                if (we_q) begin
                    VRD = 1'b1;
                    // First access cycle is address setup; strobe afterwards.
                    VWE = (acc_cnt == ACC_LOAD);
                end else begin
                    VOE = 1'b0;
                end
                if (acc_last) state_nxt = ACK;
            end
            ACK: begin
                cpu_ack   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cpu_busy = (state != IDLE);

`ifdef ATHENA_SIDE_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (VIDEO_RST) begin
            stall_cnt <= '0;
        end else if (state == WAIT && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/athena_side_vram_arbiter.md
Name: athena_side_vram_arbiter

Overview:
- Sequences the side-layer 2Kx8 VRAM and shares it between the CPU (Z80 port) and the side-layer video fetch.
- Generates the per-pixel phase and the tile-pipeline strobes (VLK, H2n, H1n, H0n cens).
- Generates the address-mux select V_C and the SRAM/transceiver controls (SIDE_VRAM_CSn, VOE, VWE, VDG, VRD).
- Runs the CPU transaction state machine: single-pulse request, slot wait, access, acknowledge. Sits between the CPU bus decode and the side-layer datapath.

Parameters:
- ACC_CYC, 2, clk cycles SRAM chip-select is held for a CPU access (1..4).
- VID_SLOT_START, 6, first pixel phase (0..7) reserved for video fetch; the slot runs through phase 7.

Ports:
- clk  in  1  system clock
- VIDEO_RST  in  1  synchronous reset, active-high
- CK1  in  1  pixel clock-enable, one clk wide per pixel
- cpu_req  in  1  single-cycle request pulse
- cpu_we  in  1  1=write, 0=read; sampled with cpu_req
- cpu_addr  in  11  VRAM address; sampled with cpu_req
- cpu_din  in  8  write data; sampled with cpu_req
- cpu_dout  out  8  read data; valid during cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- cpu_busy  out  1  transaction outstanding
- VA  out  11  latched CPU address to the datapath
- VD_wr  out  8  latched write data
- VD_rd  in  8  SRAM read data from the datapath
- V_C  out  1  mux select: 1=CPU address, 0=video address
- SIDE_VRAM_CSn, VOE, VWE, VDG, VRD  out  1 each  active-low SRAM/transceiver controls; VRD=1 means CPU→SRAM direction
- VLK, H2n, H1n, H0n  out  1 each  single-cycle pipeline cens
- phase  out  3  current pixel phase

Behaviour:
- Reset values:
  - phase=0, V_C=1.
  - SIDE_VRAM_CSn=VOE=VWE=VDG=1, VRD=0.
  - VLK=H2n=H1n=H0n=0.
  - cpu_ack=0, cpu_busy=0, cpu_dout=0, VA=0, VD_wr=0.
  - FSM state=IDLE.
- Phase counter: increments modulo 8 on each clk with CK1=1, and holds otherwise.
- Strobes: all registered and asserted for exactly one clk. With p = the phase value before the increment:
  - VLK on the CK1 cycle where p==7.
  - H2n on the CK1 cycle where p==1.
  - H1n on the CK1 cycle where p==3.
  - H0n on the CK1 cycle where p==5.
- Video window: V_C=0 whenever phase is in [VID_SLOT_START..7]. V_C=1 otherwise. The CPU never drives the SRAM in this window.
- FSM states: IDLE, WAIT, ACCESS, ACK.
  - IDLE: on cpu_req, latch we/addr/din into VA/VD_wr, set cpu_busy=1, go to WAIT.
  - WAIT: on a CK1 cycle with phase ≤ VID_SLOT_START-3, go to ACCESS. This guarantees ACCESS ends before the video window, provided ACC_CYC ≤ 2 pixel periods.
  - ACCESS: for ACC_CYC clks, drive SIDE_VRAM_CSn=0 and VDG=0.
    - Write: VRD=1, VWE=0 during the last ACC_CYC-1 clks only (address setup before the write strobe).
    - Read: VRD=0, VOE=0 for all ACC_CYC clks.
    - On the final cycle, capture VD_rd into cpu_dout (reads only), then go to ACK.
  - ACK: cpu_ack=1 for one clk, drop the controls to inactive, cpu_busy=0 on the following cycle, go to IDLE.
- Boundaries:
  - cpu_req while cpu_busy=1 is ignored and does not alter the latched request.
  - cpu_req arriving in the same clk as ACK is ignored.
  - A request latched during the video window waits for the next phase-0 CK1.
  - Worst-case latency, req to ack: 8 pixels + ACC_CYC + 2 clk.
  - cpu_dout holds its last read value until the next read completes; writes do not change it.
  - VIDEO_RST mid-transaction: abort immediately to the reset values. No ack, and no write strobe in the following cycle.

Optional Feature:
- Macro: ATHENA_SIDE_ARB_STATS_EN.
- Defined:
  - Adds output stall_cnt [15:0], which increments on every clk spent in WAIT and saturates at 16'hFFFF.
  - Cleared by VIDEO_RST.
- Undefined: the port and counter are absent, and the block is otherwise identical.

Decomposition:
- Shared package athena_side_pkg holds:
  - enum arb_state_t {IDLE, WAIT, ACCESS, ACK};
  - localparams PH_VLK=7, PH_H2=1, PH_H1=3, PH_H0=5;
  - typedef phase_t (logic [2:0]).
- One natural sub-module: athena_side_phase_gen, containing the phase counter, the strobe generation and the V_C window. The FSM stays in the top level.

Test Plan:
- Free-running CK1 every 4 clk, no requests -> phase cycles 0..7; VLK/H2n/H1n/H0n each pulse once per 8 pixels at phases 7/1/3/5; V_C=0 exactly during phases 6-7.
- Write req addr=0x3A5 din=0x5C at phase 0 -> CSn low 2 clk, VWE low 1 clk with VA=0x3A5 and VD_wr=0x5C, VRD=1; cpu_ack pulses; no CSn activity while V_C=0.
- Read req at phase 6 with VD_rd=0xA7 -> waits for phase 0; VOE low 2 clk; cpu_ack with cpu_dout=0xA7.
- Second cpu_req pulse while busy -> ignored; exactly one ack; VA unchanged.
- VIDEO_RST asserted during ACCESS -> next clk: CSn=VWE=VOE=1, cpu_busy=0, no ack ever issued.
- With ATHENA_SIDE_ARB_STATS_EN: request at phase 6, CK1 every 4 clk -> stall_cnt equals the WAIT cycle count; it saturates when forced near 16'hFFFF.
